// File: rtl/spi_flash_arbiter.sv
// Two-port arbiter in front of the SPI flash word reader.
// Define SPI_FLASH_ARB_CACHE_EN to add a one-entry read cache.
module spi_flash_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int ROUND_ROBIN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [31:0]       rdata,
  output logic              flash_rstrb,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic [31:0]       flash_rdata,
  input  logic              flash_rbusy
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                rr_q, rr_d;
  logic                strb_q, strb_d;
  logic [ADDR_W-1:0]   faddr_q, faddr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;

  logic                v0, v1, win, hit;
  logic [ADDR_W-1:0]   win_addr;

  // A port is not re-granted in its own ack cycle.
  assign v0 = req0 & ~ack0_q;
  assign v1 = req1 & ~ack1_q;

  assign win = (v0 & v1) ? ((ROUND_ROBIN != 0) ? ~rr_q : 1'b1) : v1;
  assign win_addr = win ? addr1 : addr0;

`ifdef SPI_FLASH_ARB_CACHE_EN
  logic                cv_q, cv_d;
  logic [ADDR_W-1:0]   ctag_q, ctag_d;
  logic [31:0]         cdata_q, cdata_d;

  assign hit = cv_q && (ctag_q == win_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      cv_q    <= 1'b0;
      ctag_q  <= '0;
      cdata_q <= '0;
    end else begin
      cv_q    <= cv_d;
      ctag_q  <= ctag_d;
      cdata_q <= cdata_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    strb_d  = 1'b0;
    faddr_d = faddr_q;
    rdata_d = rdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifdef SPI_FLASH_ARB_CACHE_EN
    cv_d    = cv_q;
    ctag_d  = ctag_q;
    cdata_d = cdata_q;
`endif
    unique case (state_q)
      IDLE: begin
        if ((v0 | v1) && !flash_rbusy) begin
          gnt_d = win;
          rr_d  = win;
          if (hit) begin
            rdata_d = rdata_q;
`ifdef SPI_FLASH_ARB_CACHE_EN
            rdata_d = cdata_q;
`endif
            ack0_d = ~win;
            ack1_d = win;
          end else begin
            faddr_d = win_addr;
            strb_d  = 1'b1;
            state_d = ARM;
          end
        end
      end
      ARM: state_d = WAIT;
      WAIT: begin
        if (!flash_rbusy) begin
          rdata_d = flash_rdata;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = IDLE;
`ifdef SPI_FLASH_ARB_CACHE_EN
          cv_d    = 1'b1;
          ctag_d  = faddr_q;
          cdata_d = flash_rdata;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      strb_q  <= 1'b0;
      faddr_q <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      strb_q  <= strb_d;
      faddr_q <= faddr_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign flash_rstrb = strb_q;
  assign flash_addr  = faddr_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: fixed-priority and
// round-robin instances, each with its own flash reader model.
module tb_spi_flash_arbiter;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req0 [2];
  logic          req1 [2];
  logic          ack0 [2];
  logic          ack1 [2];
  logic          rstrb[2];
  logic          fbusy[2];
  logic [AW-1:0] addr0[2];
  logic [AW-1:0] addr1[2];
  logic [AW-1:0] faddr[2];
  logic [AW-1:0] baddr[2] = '{'0, '0};
  logic [31:0]   rdata[2];
  logic [31:0]   frdata[2];
  int unsigned   bcnt[2] = '{0, 0};
  int            nstrb[2] = '{0, 0};
  int            nbad[2] = '{0, 0};
  int            nboth = 0;
  int            lat_n = 2;
  int            glog[$];
  logic [31:0]   dlog[$];
  logic          pend0[2] = '{1'b0, 1'b0};
  logic          pend1[2] = '{1'b0, 1'b0};
  int            checks = 0;
  int            failures = 0;

  spi_flash_arbiter #(.ADDR_W(AW), .ROUND_ROBIN(0)) u_fix (
    .clk(clk), .reset(reset),
    .req0(req0[0]), .addr0(addr0[0]), .ack0(ack0[0]),
    .req1(req1[0]), .addr1(addr1[0]), .ack1(ack1[0]),
    .rdata(rdata[0]), .flash_rstrb(rstrb[0]),
    .flash_addr(faddr[0]), .flash_rdata(frdata[0]),
    .flash_rbusy(fbusy[0])
  );

  spi_flash_arbiter #(.ADDR_W(AW), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset),
    .req0(req0[1]), .addr0(addr0[1]), .ack0(ack0[1]),
    .req1(req1[1]), .addr1(addr1[1]), .ack1(ack1[1]),
    .rdata(rdata[1]), .flash_rstrb(rstrb[1]),
    .flash_addr(faddr[1]), .flash_rdata(frdata[1]),
    .flash_rbusy(fbusy[1])
  );

  function automatic logic [31:0] mdata(input logic [AW-1:0] a);
    return (a == 20'h00010) ? 32'hDEADBEEF : {12'hC0D, a};
  endfunction

  // Reader: busy rises the cycle after the strobe, for lat_n cycles.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rstrb[k]) begin
        if (bcnt[k] != 0) nbad[k] <= nbad[k] + 1;
        bcnt[k]  <= lat_n;
        baddr[k] <= faddr[k];
        nstrb[k] <= nstrb[k] + 1;
      end else if (bcnt[k] != 0) begin
        bcnt[k] <= bcnt[k] - 1;
      end
    end
  end

  assign fbusy[0]  = (bcnt[0] != 0);
  assign fbusy[1]  = (bcnt[1] != 0);
  assign frdata[0] = mdata(baddr[0]);
  assign frdata[1] = mdata(baddr[1]);

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ack0[k]) begin
        glog.push_back(k * 2);
        dlog.push_back(rdata[k]);
      end
      if (ack1[k]) begin
        glog.push_back(k * 2 + 1);
        dlog.push_back(rdata[k]);
      end
      if (ack0[k] && ack1[k]) nboth <= nboth + 1;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        assert (!(pend0[k] && !req0[k] && !ack0[k]))
          else $error("req0 dropped before its ack");
        assert (!(pend1[k] && !req1[k] && !ack1[k]))
          else $error("req1 dropped before its ack");
        pend0[k] <= req0[k] && !ack0[k];
        pend1[k] <= req1[k] && !ack1[k];
      end
    end
  end

  function automatic int gl(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  function automatic logic [31:0] dl(input int i);
    return (i < dlog.size()) ? dlog[i] : 32'hBAD0BAD0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input int n0, input int n1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       output int cyc);
    int r0, r1;
    r0 = n0;
    r1 = n1;
    addr0[k] = a0;
    addr1[k] = a1;
    req0[k] = (n0 > 0);
    req1[k] = (n1 > 0);
    cyc = 0;
    while ((r0 > 0 || r1 > 0) && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (ack0[k] && r0 > 0) begin
        r0--;
        if (r0 == 0) req0[k] = 1'b0;
      end
      if (ack1[k] && r1 > 0) begin
        r1--;
        if (r1 == 0) req1[k] = 1'b0;
      end
    end
    chk("drive_done", 64'(r0 + r1), 64'd0);
    req0[k] = 1'b0;
    req1[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc, s, g, b;
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b0;
      req1[k] = 1'b0;
      addr0[k] = '0;
      addr1[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ack0", ack0[0], 1'b0);
    chk("rst_ack1", ack1[1], 1'b0);
    chk("rst_strb", rstrb[0], 1'b0);
    chk("rst_faddr", faddr[0], 64'd0);
    chk("rst_rdata", rdata[1], 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // single read, 64-cycle busy window
    lat_n = 64;
    s = nstrb[0];
    g = glog.size();
    drive(0, 1, 0, 20'h00010, 20'h0, cyc);
    chk("t1_latency", 64'(cyc), 64'd67);
    chk("t1_strobes", 64'(nstrb[0] - s), 64'd1);
    chk("t1_faddr", baddr[0], 20'h00010);
    chk("t1_port", 64'(gl(g)), 64'd0);
    chk("t1_rdata", dl(g), 32'hDEADBEEF);

    // simultaneous requests, fixed priority
    lat_n = 2;
    s = nstrb[0];
    g = glog.size();
    drive(0, 1, 1, 20'h00020, 20'h00021, cyc);
    chk("t2_first", 64'(gl(g)), 64'd1);
    chk("t2_second", 64'(gl(g + 1)), 64'd0);
    chk("t2_d1", dl(g), 32'hC0D00021);
    chk("t2_d0", dl(g + 1), 32'hC0D00020);
    chk("t2_strobes", 64'(nstrb[1 - 1] - s), 64'd2);
    chk("t2_acks", 64'(glog.size() - g), 64'd2);
    chk("t2_cycles", 64'(cyc), 64'd10);

    // round robin, both held for four transactions
    g = glog.size();
    drive(1, 2, 2, 20'h00030, 20'h00031, cyc);
    chk("t3_g0", 64'(gl(g)), 64'd3);
    chk("t3_g1", 64'(gl(g + 1)), 64'd2);
    chk("t3_g2", 64'(gl(g + 2)), 64'd3);
    chk("t3_g3", 64'(gl(g + 3)), 64'd2);
    chk("t3_d3", dl(g + 3), 32'hC0D00030);

    // port 1 served alone, then a conflict
    drive(0, 0, 1, 20'h0, 20'h00050, cyc);
    g = glog.size();
    drive(0, 1, 1, 20'h00051, 20'h00052, cyc);
    chk("fix_after_p1", 64'(gl(g)), 64'd1);
    drive(1, 0, 1, 20'h0, 20'h00050, cyc);
    g = glog.size();
    drive(1, 1, 1, 20'h00051, 20'h00052, cyc);
    chk("rr_after_p1", 64'(gl(g)), 64'd2);

    // reset while the reader is still busy
    lat_n = 20;
    s = nstrb[0];
    b = nbad[0];
    g = glog.size();
    addr0[0] = 20'h00040;
    req0[0] = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_no_ack", 64'(glog.size() - g), 64'd0);
    chk("t4_rdata_rst", rdata[0], 64'd0);
    cyc = 0;
    while (!ack0[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_ack", ack0[0], 1'b1);
    req0[0] = 1'b0;
    chk("t4_cycles", 64'(cyc), 64'd39);
    chk("t4_rdata", rdata[0], 32'hC0D00040);
    chk("t4_strobes", 64'(nstrb[0] - s), 64'd2);
    chk("t4_busy_strb", 64'(nbad[0] - b), 64'd0);
    @(negedge clk);

    lat_n = 3;
    s = nstrb[0];
    g = glog.size();
    drive(0, 1, 0, 20'h00100, 20'h0, cyc);
    chk("rep_first", 64'(cyc), 64'd6);
    drive(0, 1, 0, 20'h00100, 20'h0, cyc);
    chk("rep_d0", dl(g), 32'hC0D00100);
    chk("rep_d1", dl(g + 1), 32'hC0D00100);
`ifdef SPI_FLASH_ARB_CACHE_EN
    chk("t5_latency", 64'(cyc), 64'd1);
    chk("t5_strobes", 64'(nstrb[0] - s), 64'd1);
    s = nstrb[0];
    g = glog.size();
    drive(0, 1, 0, 20'h00200, 20'h0, cyc);
    drive(0, 1, 0, 20'h00300, 20'h0, cyc);
    drive(0, 1, 0, 20'h00200, 20'h0, cyc);
    chk("t6_strobes", 64'(nstrb[0] - s), 64'd3);
    chk("t6_d2", dl(g + 2), 32'hC0D00200);
`else
    chk("nc_latency", 64'(cyc), 64'd6);
    chk("nc_strobes", 64'(nstrb[0] - s), 64'd2);
`endif

    chk("ack_overlap", 64'(nboth), 64'd0);
    chk("busy_strb_all", 64'(nbad[0] + nbad[1]), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
